pipelined_addsub: RTL and testbench



---
 rtl/addsub_pkg.sv | 18 +
 rtl/cla4_group.sv | 29 ++
 rtl/pipelined_addsub.sv | 142 ++++++++++++++
 tb/tb_pipelined_addsub.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor: group width,
// stage-count helper and the result flag bundle.
package addsub_pkg;

    localparam int GROUP_W = 4;

    typedef struct packed {
        logic cout;
        logic overflow;
        logic zero;
        logic negative;
    } flags_t;

    function automatic int num_stages(input int width, input int gps);
        return ((width / GROUP_W) + gps - 1) / gps;
    endfunction

endpackage

// File: rtl/cla4_group.sv
// Combinational 4-bit carry-lookahead group; also exposes the carry into
// bit 3 so the top can form signed overflow at the MSB group.
module cla4_group (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout,
    output logic       c3
);

    logic [3:0] p;
    logic [3:0] g;
    logic       c1;
    logic       c2;

    assign p = a ^ b;
    assign g = a & b;

    assign c1 = g[0] | (p[0] & cin);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (&p & cin);

    assign sum = p ^ {c3, c2, c1, cin};

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement add/sub built from 4-bit lookahead groups with a
// registered carry between stages, valid/ready backpressure and optional saturation.
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH            = 16,
    parameter int GROUPS_PER_STAGE = 1,
    parameter int SATURATE         = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int NG = WIDTH / GROUP_W;
    localparam int NS = num_stages(WIDTH, GROUPS_PER_STAGE);

    // b is stored already conditioned (inverted for subtract); carry holds the
    // carry into the first group not yet evaluated.
    typedef struct packed {
        logic             valid;
        logic             sat;
        logic             carry;
        logic             c_msb;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] sum;
        flags_t           flags;
    } stage_t;

    stage_t           src     [NS];
    stage_t           nxt     [NS];
    stage_t           stage_q [NS];
    stage_t           fin;
    logic             stall;
    logic [WIDTH-1:0] grp_sum;
    logic [NG-1:0]    grp_cout;
    logic [NG-1:0]    grp_c3;

    always_comb begin
        src[0]       = '0;
        src[0].valid = in_valid;
        src[0].sat   = (SATURATE != 0) && sat;
        src[0].carry = sub;
        src[0].a     = a;
        src[0].b     = sub ? ~b : b;
        for (int s = 1; s < NS; s++) begin
            src[s] = stage_q[s-1];
        end
    end

    for (genvar g = 0; g < NG; g++) begin : gen_grp
        localparam int S = g / GROUPS_PER_STAGE;
        logic       cin_g;
        logic       cout_g;
        logic       c3_g;
        logic [3:0] sum_g;

        // The first group of each stage takes the registered carry; the rest ripple.
        if (g % GROUPS_PER_STAGE == 0) begin : gen_head
            assign cin_g = src[S].carry;
        end else begin : gen_chain
            assign cin_g = gen_grp[g-1].cout_g;
        end

        cla4_group u_grp (
            .a    (src[S].a[GROUP_W*g +: GROUP_W]),
            .b    (src[S].b[GROUP_W*g +: GROUP_W]),
            .cin  (cin_g),
            .sum  (sum_g),
            .cout (cout_g),
            .c3   (c3_g)
        );

        assign grp_sum[GROUP_W*g +: GROUP_W] = sum_g;
        assign grp_cout[g]                   = cout_g;
        assign grp_c3[g]                     = c3_g;
    end

    always_comb begin
        int lg;
        for (int s = 0; s < NS; s++) begin
            nxt[s] = src[s];
            lg     = (((s + 1) * GROUPS_PER_STAGE < NG) ? (s + 1) * GROUPS_PER_STAGE : NG) - 1;
            for (int i = 0; i < WIDTH; i++) begin
                if ((i / GROUP_W) / GROUPS_PER_STAGE == s) begin
                    nxt[s].sum[i] = grp_sum[i];
                end
            end
            nxt[s].carry = grp_cout[lg];
            nxt[s].c_msb = grp_c3[lg];
        end
    end

    always_comb begin
        fin                = nxt[NS-1];
        fin.flags.cout     = nxt[NS-1].carry;
        fin.flags.overflow = nxt[NS-1].c_msb ^ nxt[NS-1].carry;
        if (nxt[NS-1].sat && fin.flags.overflow) begin
            fin.sum = {nxt[NS-1].a[WIDTH-1], {(WIDTH-1){~nxt[NS-1].a[WIDTH-1]}}};
        end
        fin.flags.zero     = (fin.sum == '0);
        fin.flags.negative = fin.sum[WIDTH-1];
    end

    // Whole pipeline freezes on stall; bubbles are never squeezed out.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NS; s++) begin
                stage_q[s] <= '0;
            end
        end else if (!stall) begin
            for (int s = 0; s < NS - 1; s++) begin
                stage_q[s] <= nxt[s];
            end
            stage_q[NS-1] <= fin;
        end
    end

    assign out_valid = stage_q[NS-1].valid;
    assign sum       = stage_q[NS-1].sum;
    assign cout      = stage_q[NS-1].flags.cout;
    assign overflow  = stage_q[NS-1].flags.overflow;
    assign zero      = stage_q[NS-1].flags.zero;
    assign negative  = stage_q[NS-1].flags.negative;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: three configurations checked against an
// arithmetic reference model (directed, random back-to-back, reset flush).
module tb_pipelined_addsub;

    logic        clk;
    logic        rst;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        sub_in;
    logic        sat_in;
    logic        iv   [3];
    logic        ordy [3];

    logic        ov [3];
    logic        ir [3];
    logic [31:0] so [3];
    logic        co [3];
    logic        of [3];
    logic        zr [3];
    logic        ng [3];

    logic [15:0] s0;
    logic [15:0] s1;
    logic [31:0] s2;

    int checks   = 0;
    int failures = 0;

    int width_of [3] = '{16, 16, 32};
    int lat_of   [3] = '{4, 4, 3};
    int sat_en   [3] = '{1, 0, 1};

    always #5 clk = ~clk;

    pipelined_addsub #(.WIDTH(16), .GROUPS_PER_STAGE(1), .SATURATE(1)) dut_16s (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(a_in[15:0]), .b(b_in[15:0]), .sub(sub_in), .sat(sat_in),
        .out_valid(ov[0]), .out_ready(ordy[0]), .sum(s0), .cout(co[0]),
        .overflow(of[0]), .zero(zr[0]), .negative(ng[0])
    );

    pipelined_addsub #(.WIDTH(16), .GROUPS_PER_STAGE(1), .SATURATE(0)) dut_16n (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(a_in[15:0]), .b(b_in[15:0]), .sub(sub_in), .sat(sat_in),
        .out_valid(ov[1]), .out_ready(ordy[1]), .sum(s1), .cout(co[1]),
        .overflow(of[1]), .zero(zr[1]), .negative(ng[1])
    );

    pipelined_addsub #(.WIDTH(32), .GROUPS_PER_STAGE(3), .SATURATE(1)) dut_32 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(a_in), .b(b_in), .sub(sub_in), .sat(sat_in),
        .out_valid(ov[2]), .out_ready(ordy[2]), .sum(s2), .cout(co[2]),
        .overflow(of[2]), .zero(zr[2]), .negative(ng[2])
    );

    assign so[0] = {16'h0, s0};
    assign so[1] = {16'h0, s1};
    assign so[2] = s2;

    // Result packed as {sum[31:0], cout, overflow, zero, negative}.
    function automatic logic [35:0] ref_model(input int w, input logic [31:0] ta,
                                              input logic [31:0] tb_, input logic ts,
                                              input logic tsat);
        longint mod, ua, ub, res, sa, sb, ex, smax, smin;
        logic   c, o;
        mod  = longint'(1) << w;
        ua   = {32'h0, ta} & (mod - 1);
        ub   = {32'h0, tb_} & (mod - 1);
        if (ts) begin
            res = (ua - ub + mod) % mod;
            c   = (ua >= ub);
        end else begin
            res = (ua + ub) % mod;
            c   = ((ua + ub) >= mod);
        end
        sa   = (ua >= mod / 2) ? ua - mod : ua;
        sb   = (ub >= mod / 2) ? ub - mod : ub;
        ex   = ts ? sa - sb : sa + sb;
        smax = mod / 2 - 1;
        smin = -(mod / 2);
        o    = (ex > smax) || (ex < smin);
        if (tsat && o) res = (ex > smax) ? smax : mod / 2;
        return {res[31:0], c, o, (res == 0), res[w-1]};
    endfunction

    task automatic test_reset();
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({ov[d], ir[d], so[d], co[d], of[d], zr[d], ng[d]} !== {1'b0, 1'b1, 36'h0}) begin
                failures++;
                $display("FAIL reset d%0d: valid=%b ready=%b sum=%h flags=%b%b%b%b required valid=0 ready=1 sum=0 flags=0000",
                         d, ov[d], ir[d], so[d], co[d], of[d], zr[d], ng[d]);
            end
        end
    endtask

    task automatic run_case(input string nm, input logic [31:0] ta, input logic [31:0] tb_,
                            input logic ts, input logic tsat);
        logic [35:0] e [3];
        logic [35:0] obs;
        @(posedge clk); #1;
        a_in = ta; b_in = tb_; sub_in = ts; sat_in = tsat;
        for (int d = 0; d < 3; d++) begin
            iv[d]   = 1'b1;
            ordy[d] = 1'b1;
            e[d]    = ref_model(width_of[d], ta, tb_, ts, tsat && (sat_en[d] != 0));
        end
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) iv[d] = 1'b0;
        a_in = $urandom; b_in = $urandom;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (ov[d] !== (c == lat_of[d])) begin
                    failures++;
                    $display("FAIL %s d%0d valid@%0d: got %b required %b", nm, d, c, ov[d], (c == lat_of[d]));
                end
                if (c == lat_of[d]) begin
                    obs = {so[d], co[d], of[d], zr[d], ng[d]};
                    checks++;
                    if (obs !== e[d]) begin
                        failures++;
                        $display("FAIL %s d%0d result: got sum=%h c/o/z/n=%b required sum=%h c/o/z/n=%b",
                                 nm, d, obs[35:4], obs[3:0], e[d][35:4], e[d][3:0]);
                    end
                end
            end
        end
    endtask

    task automatic test_directed();
        run_case("add_0fff_1",     32'h0000_0FFF, 32'h1, 1'b0, 1'b0);
        run_case("add_7fff_1_nos", 32'h0000_7FFF, 32'h1, 1'b0, 1'b0);
        run_case("add_7fff_1_sat", 32'h0000_7FFF, 32'h1, 1'b0, 1'b1);
        run_case("sub_5_5",        32'h5,         32'h5, 1'b1, 1'b0);
        run_case("sub_0_1",        32'h0,         32'h1, 1'b1, 1'b0);
        run_case("sub_8000_1_sat", 32'h0000_8000, 32'h1, 1'b1, 1'b1);
        run_case("sub_8000_1_nos", 32'h0000_8000, 32'h1, 1'b1, 1'b0);
        run_case("add_7fffffff_s", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1);
        run_case("add_ffffffff_1", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
        run_case("sub_80000000_s", 32'h8000_0000, 32'h1, 1'b1, 1'b1);
    endtask

    task automatic test_back_to_back(input int d);
        logic [35:0] exp_q [$];
        logic [35:0] obs, prev_obs, e;
        logic        prev_stall, stall_now;
        int          sent, recv, cyc;
        sent = 0; recv = 0; cyc = 0; prev_stall = 1'b0; prev_obs = '0;
        while ((sent < 8 || recv < 8) && cyc < 200) begin
            @(posedge clk); #1;
            iv[d] = (sent < 8);
            if (sent < 8) begin
                a_in   = $urandom;
                b_in   = $urandom;
                sub_in = 1'($urandom_range(0, 1));
                sat_in = 1'($urandom_range(0, 1));
            end
            ordy[d] = (cyc % 2 == 0);
            @(negedge clk);
            obs = {so[d], co[d], of[d], zr[d], ng[d]};
            if (prev_stall) begin
                checks++;
                if (ov[d] !== 1'b1 || obs !== prev_obs) begin
                    failures++;
                    $display("FAIL b2b_hold d%0d: valid=%b out=%h required valid=1 out=%h", d, ov[d], obs, prev_obs);
                end
            end
            stall_now = ov[d] & ~ordy[d];
            checks++;
            if (ir[d] !== ~stall_now) begin
                failures++;
                $display("FAIL b2b_in_ready d%0d: got %b required %b", d, ir[d], ~stall_now);
            end
            if (ov[d] === 1'b1 && ordy[d]) begin
                checks++;
                recv++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_extra d%0d: got out=%h required no output", d, obs);
                end else begin
                    e = exp_q.pop_front();
                    if (obs !== e) begin
                        failures++;
                        $display("FAIL b2b_result d%0d #%0d: got %h required %h", d, recv, obs, e);
                    end
                end
            end
            if (iv[d] && !stall_now) begin
                exp_q.push_back(ref_model(width_of[d], a_in, b_in, sub_in, sat_in && (sat_en[d] != 0)));
                sent++;
            end
            prev_stall = stall_now;
            prev_obs   = obs;
            cyc++;
        end
        @(posedge clk); #1;
        iv[d]   = 1'b0;
        ordy[d] = 1'b1;
        checks++;
        if (recv < 8 || sent < 8) begin
            failures++;
            $display("FAIL b2b_timeout d%0d: got sent=%0d recv=%0d required 8/8", d, sent, recv);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (ov[d] !== 1'b0) begin
                failures++;
                $display("FAIL b2b_drain d%0d: got valid=%b required 0", d, ov[d]);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            a_in  = $urandom; b_in = $urandom;
            iv[0] = 1'b1;
            iv[1] = 1'b1;
            iv[2] = (c != 0);
            rst   = (c == 3);
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (ov[d] !== 1'b0) begin
                    failures++;
                    $display("FAIL rst_mid_pre d%0d cyc%0d: got valid=%b required 0", d, c, ov[d]);
                end
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int d = 0; d < 3; d++) iv[d] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (ov[d] !== 1'b0 || ir[d] !== 1'b1) begin
                    failures++;
                    $display("FAIL rst_mid_flush d%0d cyc%0d: got valid=%b ready=%b required valid=0 ready=1",
                             d, c, ov[d], ir[d]);
                end
            end
            if (c < 7) @(posedge clk);
        end
        run_case("post_reset_add", 32'h1234_0FFF, 32'h0000_F001, 1'b0, 1'b0);
        run_case("post_reset_sub", 32'h0000_0003, 32'h0000_0007, 1'b1, 1'b1);
    endtask

    initial begin
        clk    = 1'b0;
        rst    = 1'b1;
        a_in   = '0;
        b_in   = '0;
        sub_in = 1'b0;
        sat_in = 1'b0;
        for (int d = 0; d < 3; d++) begin
            iv[d]   = 1'b0;
            ordy[d] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_directed();
        for (int d = 0; d < 3; d++) test_back_to_back(d);
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
